uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx_cfg.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes,
// receiver FSM states and the per-frame error flags stored with each byte.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic frame_err;
        logic parity_err;
    } rx_err_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with registered storage; the head entry is presented whenever
// the FIFO is non-empty. A push into a full FIFO is dropped unless a pop
// frees the head slot in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        full    = (count == (PTR_W + 1)'(DEPTH));
        pop_ok  = pop && (count != '0);
        // When full, the slot being popped is the one the write pointer targets.
        push_ok = push && (!full || pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
            overrun <= push && full && !pop_ok;
        end
    end

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign level    = count;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchronizer, mid-bit sampling
// FSM with optional parity and 1-2 stop bits, feeding a small receive FIFO.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          serialStream,
    input  logic                          rdReady,
    output logic                          rdValid,
    output logic [DATA_BITS-1:0]          rdData,
    output logic                          parityErr,
    output logic                          frameErr,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 sync1;
    logic                 sync2;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     bit_idx_next;
    logic                 stop_idx;
    logic                 stop_idx_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_next;
    rx_err_t              err;
    rx_err_t              err_next;
    logic                 last_stop;
    logic                 push;
    logic [WORD_W-1:0]    push_word;
    logic [WORD_W-1:0]    head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            err      <= '0;
        end else begin
            sync1    <= serialStream;
            sync2    <= sync1;
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
            shreg    <= shreg_next;
            err      <= err_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        shreg_next    = shreg;
        err_next      = err;
        push          = 1'b0;
        push_word     = {err.frame_err, err.parity_err, shreg};
        last_stop     = (STOP_BITS == 1) ? 1'b1 : stop_idx;

        case (state)
            IDLE: begin
                if (!sync2) begin
                    cnt_next      = '0;
                    bit_idx_next  = '0;
                    stop_idx_next = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_next = '0;
                    if (!sync2) begin
                        err_next   = '0;
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    // LSB arrives first, so shifting right leaves it in bit 0.
                    shreg_next = {sync2, shreg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_next = '0;
                        state_next   = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_next            = '0;
                    err_next.parity_err = ((^shreg) ^ sync2) != (PARITY_MODE == PAR_ODD);
                    state_next          = STOP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next           = '0;
                    err_next.frame_err = err.frame_err | ~sync2;
                    if (last_stop) begin
                        push       = 1'b1;
                        push_word  = {err.frame_err | ~sync2, err.parity_err, shreg};
                        state_next = IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    uart_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (rdReady),
        .rd_valid  (rdValid),
        .rd_data   (head),
        .level     (fifoLevel),
        .overrun   (overrun)
    );

    assign rdData    = head[DATA_BITS-1:0];
    assign parityErr = head[DATA_BITS];
    assign frameErr  = head[DATA_BITS+1];

endmodule
